range_shifter: RTL and testbench

- Converts a signed fixed-point angle (radians, Q3.8: 1 sign, 2 integer, 8 fraction bits) in the range [-pi, +pi] to an unsigned 8-bit position code in [0, 255].
- Sits between the angle-computation stage of the tracking path and the DMX channel formatter (pan/tilt byte).
- Linear map: -pi -> 0, +pi -> 255. Out-of-range inputs saturate.

---
 rtl/range_shifter.sv | 50 +++++
 tb/tb_range_shifter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/range_shifter.sv
// range_shifter: maps a Q3.8 angle in [-pi,+pi] to an 8-bit position code, 2-cycle pipeline.
// Define RANGE_SHIFTER_INVERT_EN to reverse the output direction.
module range_shifter #(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 8,
  parameter int PI_CODE = 804
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in,
  output logic        [OUT_W-1:0] out
);
  localparam int PW = IN_W + 1 + OUT_W;
  localparam int SH = 30;
  localparam logic signed [IN_W:0] PI_S  = (IN_W+1)'(PI_CODE);
  localparam logic signed [IN_W:0] NPI_S = -PI_S;
  localparam logic [OUT_W-1:0]     OUT_MAX = '1;
  localparam logic [PW-1:0]        DEN = PW'(2 * PI_CODE);
  localparam logic [PW+SH-1:0]     RECIP = (PW+SH)'((64'd1 << SH) / (2 * PI_CODE));
  logic signed [IN_W:0] w_s, w_c;
  logic [IN_W:0]        r_u;
  logic                 r_v;
  logic [PW-1:0]        w_p, w_q0, w_r, w_q;
  logic [PW+SH-1:0]     w_m;
  logic [OUT_W-1:0]     w_o;
  assign w_s = {in[IN_W-1], in};
  assign w_c = w_s < NPI_S ? NPI_S : w_s > PI_S ? PI_S : w_s;
  assign w_p = PW'(r_u) * PW'(OUT_MAX);
  // Reciprocal estimate is floor(p/DEN) or one below it; the remainder test fixes it up.
  assign w_m  = (PW+SH)'(w_p) * RECIP;
  assign w_q0 = PW'(w_m >> SH);
  assign w_r  = w_p - w_q0 * DEN;
  assign w_q  = w_r >= DEN ? w_q0 + 1'b1 : w_q0;
`ifdef RANGE_SHIFTER_INVERT_EN
  assign w_o = OUT_MAX - OUT_W'(w_q);
`else
  assign w_o = OUT_W'(w_q);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_u <= '0;
      r_v <= 1'b0;
      out <= '0;
    end else begin
      r_u <= $unsigned(w_c + PI_S);
      r_v <= 1'b1;
      out <= r_v ? w_o : '0;
    end
  end
endmodule

// File: tb/tb_range_shifter.sv
// tb_range_shifter: directed and exhaustive checks of range_shifter against a floor-division model.
module tb_range_shifter;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [10:0] in = '0;
  logic [7:0]         out;
  int checks = 0;
  int errors = 0;

  range_shifter dut (.clk(clk), .reset(reset), .in(in), .out(out));

  always #5 clk = ~clk;

  function automatic int adj(input int v);
`ifdef RANGE_SHIFTER_INVERT_EN
    return 255 - v;
`else
    return v;
`endif
  endfunction

  function automatic int model(input int s);
    int c;
    c = s < -804 ? -804 : s > 804 ? 804 : s;
    return adj(((c + 804) * 255) / 1608);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int exp);
    checks++;
    if (int'(out) !== exp) begin
      errors++;
      $display("FAIL %s: out=%0d expected=%0d", name, out, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in = 11'b00011010110;
    step();
    check("reset_cycle1", 0);
    step();
    check("reset_cycle2", 0);
    reset = 1'b0;
    step();
    check("reset_release_first", 0);
    step();
    check("reset_first_sample", adj(161));
  endtask

  task automatic hold(input string name, input int s, input int exp);
    in = 11'(s);
    step();
    step();
    check(name, exp);
  endtask

  task automatic test_nominal();
    hold("nominal_214", 214, adj(161));
    hold("nominal_zero", 0, adj(127));
  endtask

  task automatic test_endpoints();
    hold("neg_pi", -804, adj(0));
    hold("pos_pi", 804, adj(255));
  endtask

  task automatic test_saturation();
    hold("sat_1000", 1000, adj(255));
    hold("sat_1023", 1023, adj(255));
    hold("sat_m900", -900, adj(0));
    hold("sat_m1024", -1024, adj(0));
  endtask

  task automatic test_back_to_back();
    int vin[4]  = '{-804, 0, 214, 804};
    int vexp[4] = '{0, 127, 161, 255};
    in = 11'(vin[0]);
    step();
    for (int i = 1; i < 4; i++) begin
      in = 11'(vin[i]);
      step();
      check($sformatf("b2b_%0d", i - 1), adj(vexp[i - 1]));
    end
    step();
    check("b2b_3", adj(vexp[3]));
  endtask

  task automatic test_sweep();
    int prev = -1;
    int sweep_errs = 0;
    for (int i = 0; i <= 2048; i++) begin
      if (i < 2048) in = 11'(i - 1024);
      step();
      if (i >= 1) begin
        checks++;
        if (int'(out) !== model(i - 1025)) begin
          errors++;
          sweep_errs++;
          if (sweep_errs <= 10) $display("FAIL sweep in=%0d: out=%0d expected=%0d", i - 1025, out, model(i - 1025));
        end
        if (prev >= 0) begin
          checks++;
`ifdef RANGE_SHIFTER_INVERT_EN
          if (int'(out) > prev) begin
`else
          if (int'(out) < prev) begin
`endif
            errors++;
            sweep_errs++;
            if (sweep_errs <= 10) $display("FAIL monotonic in=%0d: out=%0d previous=%0d", i - 1025, out, prev);
          end
        end
        prev = int'(out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_endpoints();
    test_saturation();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
